// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit period, frame state
// encoding and the parity rule used by both transmit and receive sides.
package uart_pkg;

  localparam int unsigned DATA_BITS            = 32;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 10417;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // parity_type 1: even (XOR of data); 0: odd (XNOR of data)
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                      input logic                 parity_type);
    return parity_type ? (^data) : ~(^data);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and wraps to 0.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - force the count to 0 (priority over enable)
//   enable    - advance the count this cycle
//   bit_done  - combinational pulse on the last cycle of a bit period
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count_q, count_d;

  assign bit_done = enable && (count_q == LAST);

  // Next count: clear wins, otherwise advance and wrap at the bit boundary
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = bit_done ? '0 : count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit stage: one-word holding buffer feeding a frame shifter.
// Frame = start(0), 32 data bits LSB first, parity, stop(1). A word waiting
// in the buffer is loaded at the end of the stop bit so frames run back to
// back without an idle cell. The frame width is uart_pkg::DATA_BITS (32).
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   tx_data      - word to send, sampled on the acceptance edge
//   tx_valid     - tx_data is valid
//   tx_ready     - holding buffer empty (registered)
//   parity_type  - 1 even / 0 odd, sampled with tx_data
//   tx           - serial line, registered, idles high
//   busy         - frame in progress or word buffered (registered)
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_type,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned IW = $clog2(DATA_BITS);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] buf_data_q, buf_data_d;
  logic                 buf_parity_q, buf_parity_d;
  logic                 buf_full_q, buf_full_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 bit_done;
  logic                 accept;
  logic                 drain;

  // Accept only into an empty buffer; drain requires a full one, so the two never coincide
  assign accept = tx_valid && !buf_full_q;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q == IDLE),
    .enable   (state_q != IDLE),
    .bit_done (bit_done)
  );

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      buf_data_q   <= '0;
      buf_parity_q <= 1'b0;
      buf_full_q   <= 1'b0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      bit_idx_q    <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      buf_data_q   <= buf_data_d;
      buf_parity_q <= buf_parity_d;
      buf_full_q   <= buf_full_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      bit_idx_q    <= bit_idx_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
    end
  end

  // Next state, shifter and buffer update
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    par_d        = par_q;
    bit_idx_d    = bit_idx_q;
    drain        = 1'b0;
    buf_data_d   = buf_data_q;
    buf_parity_d = buf_parity_q;
    buf_full_d   = buf_full_q;

    case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          state_d = START;
          drain   = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + IW'(1);
          if (bit_idx_q == IW'(DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (buf_full_q) begin
            state_d = START;
            drain   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (drain) begin
      shift_d    = buf_data_q;
      par_d      = buf_parity_q;
      bit_idx_d  = '0;
      buf_full_d = 1'b0;
    end

    if (accept) begin
      buf_data_d   = tx_data;
      buf_parity_d = parity_bit(tx_data, parity_type);
      buf_full_d   = 1'b1;
    end
  end

  // Output decode from next state so tx/busy/tx_ready are registered
  always_comb begin
    tx_d    = 1'b1;
    busy_d  = (state_d != IDLE) || buf_full_d;
    ready_d = !buf_full_d;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_ready = ready_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter with CLKS_PER_BIT=4. A line
// monitor captures every frame cell by cell and compares it with a frame
// built from the offered word by counting ones.
module tb_uart_transmitter;

  localparam int unsigned CPB        = 4;
  localparam int unsigned FRAME_BITS = 35;
  localparam int unsigned FRAME_CYC  = FRAME_BITS * CPB;

  logic        clk         = 1'b0;
  logic        rst         = 1'b0;
  logic [31:0] tx_data     = '0;
  logic        tx_valid    = 1'b0;
  logic        parity_type = 1'b0;
  logic        tx_ready;
  logic        tx;
  logic        busy;

  uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .parity_type (parity_type),
    .tx          (tx),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] data;
    logic        pt;
  } word_t;

  typedef struct {
    logic [31:0] data;
    logic        pt;
    logic        exp_par;
  } vec_t;

  int                    n_tests     = 0;
  int                    n_fail      = 0;
  int                    frames_done = 0;
  int                    n_offered   = 0;
  word_t                 exp_q[$];
  int unsigned           start_cyc[$];
  logic [FRAME_BITS-1:0] last_frame  = '0;
  int unsigned           acc_cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: bit 0 start, bits 1..32 data LSB first, 33 parity, 34 stop
  function automatic logic [FRAME_BITS-1:0] model_frame(input logic [31:0] d, input logic pt);
    int   ones;
    logic p;
    ones = $countones(d);
    p    = pt ? ((ones % 2) == 1) : ((ones % 2) == 0);
    return {1'b1, p, d, 1'b0};
  endfunction

  // Line monitor: frame starts on a low line; every cell must be constant
  initial begin : line_mon
    logic [FRAME_BITS-1:0] cap;
    logic                  stable;
    logic                  aborted;
    int unsigned           s0;
    word_t                 w;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        s0      = cyc;
        cap     = '0;
        stable  = 1'b1;
        aborted = 1'b0;
        for (int k = 0; k < int'(FRAME_CYC); k++) begin
          if (k != 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if ((k % int'(CPB)) == 0) cap[k / int'(CPB)] = tx;
          else if (tx !== cap[k / int'(CPB)]) stable = 1'b0;
        end
        if (!aborted) begin
          chk("cell_stable", 64'(stable), 64'd1);
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame_unexpected: got frame 0x%0h, expected no frame", cap);
          end else begin
            w = exp_q.pop_front();
            if (cap !== model_frame(w.data, w.pt)) begin
              n_fail++;
              $display("FAIL frame: got 0x%0h, expected 0x%0h (word 0x%08h pt %0b)",
                       cap, model_frame(w.data, w.pt), w.data, w.pt);
            end
          end
          start_cyc.push_back(s0);
          last_frame = cap;
          frames_done++;
        end
      end
    end
  end

  // Hold the word on the bus until accepted; returns #1 after the acceptance edge
  task automatic offer(input logic [31:0] d, input logic pt);
    int budget;
    budget      = 0;
    tx_data     = d;
    parity_type = pt;
    tx_valid    = 1'b1;
    while (tx_ready !== 1'b1 && budget < int'(2 * FRAME_CYC + 10)) begin
      @(negedge clk);
      budget++;
    end
    if (tx_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL offer_timeout: got tx_ready=%0b, expected 1 within %0d cycles", tx_ready, budget);
      tx_valid = 1'b0;
      return;
    end
    exp_q.push_back(word_t'{data: d, pt: pt});
    n_offered++;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic wait_frames(input int target);
    int budget;
    budget = 0;
    while (frames_done < target && budget < int'(4 * FRAME_CYC)) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (frames_done < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_frames: got %0d frames, expected %0d", frames_done, target);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t        vecs[6];
    int          ready_seen;
    int unsigned t;
    logic [31:0] w;

    vecs[0] = '{32'h0000_0001, 1'b1, 1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[2] = '{32'hA5A5_A5A5, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0003, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0000, 1'b0, 1'b1};
    vecs[5] = '{32'h8000_0000, 1'b0, 1'b0};

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(tx_ready), 64'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_tx", 64'(tx), 64'd1);

    // Single words: latency, parity, length, and input changes after acceptance
    for (int i = 0; i < 6; i++) begin
      offer(vecs[i].data, vecs[i].pt);
      tx_valid    = 1'b0;
      tx_data     = ~vecs[i].data;
      parity_type = ~vecs[i].pt;
      chk("acc_ready_low", 64'(tx_ready), 64'd0);
      chk("acc_tx_high", 64'(tx), 64'd1);
      chk("acc_busy", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      chk("start_low", 64'(tx), 64'd0);
      chk("ready_after_drain", 64'(tx_ready), 64'd1);
      wait_frames(n_offered);
      chk("parity_bit", 64'(last_frame[33]), 64'(vecs[i].exp_par));
      chk("start_latency", 64'(start_cyc[$] - acc_cyc), 64'd1);
      chk("stop_busy", 64'(busy), 64'd1);
      @(negedge clk);
      #1;
      chk("end_busy", 64'(busy), 64'd0);
      chk("end_tx", 64'(tx), 64'd1);
    end

    // Back-to-back with a full buffer and a changing bus word
    offer(32'h1234_5678, 1'b1);
    offer(32'h8765_4321, 1'b0);
    tx_data     = 32'hDEAD_BEEF;
    parity_type = 1'b1;
    ready_seen  = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_ready) ready_seen++;
    end
    chk("bp_ready_low", 64'(ready_seen), 64'd0);
    tx_valid = 1'b0;
    wait_frames(n_offered);
    chk("b2b_gap", 64'(start_cyc[$] - start_cyc[$-1]), 64'(FRAME_CYC));
    @(negedge clk);
    #1;
    chk("b2b_end_busy", 64'(busy), 64'd0);

    // Reset in the middle of data bit 10
    w = 32'hC3C3_0F0F;
    offer(w, 1'b1);
    tx_valid = 1'b0;
    t = acc_cyc + 1 + CPB * 11 + 1;
    while (cyc < t) @(negedge clk);
    chk("pre_rst_bit10", 64'(tx), 64'(w[10]));
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx", 64'(tx), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(tx_ready), 64'd1);
    exp_q.delete();
    n_offered   = frames_done;
    tx_valid    = 1'b1;
    tx_data     = 32'h0BAD_0BAD;
    parity_type = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_accept", 64'(tx_ready), 64'd1);
    rst      = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(tx_ready), 64'd1);
    @(negedge clk);
    chk("post_rst_tx", 64'(tx), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd0);
    offer(32'h0000_00FF, 1'b1);
    tx_valid = 1'b0;
    wait_frames(n_offered);
    chk("post_rst_parity", 64'(last_frame[33]), 64'd0);

    // Random words, random gaps, occasional long idle
    for (int i = 0; i < 24; i++) begin
      offer($urandom, 1'($urandom_range(0, 1)));
      tx_valid    = 1'b0;
      tx_data     = $urandom;
      parity_type = 1'($urandom_range(0, 1));
      repeat ((i % 6 == 5) ? 200 : $urandom_range(0, 3)) @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_frames(n_offered);
    chk("all_delivered", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    chk("final_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serial transmit stage for the UART link; drives the line that the UART receiver samples.
- Accepts 32-bit words over a valid/ready handshake into a one-word holding buffer.
- Frames each word as start bit, 32 data bits LSB first, one parity bit and one stop bit.
- The holding buffer permits back-to-back frames with no idle gap between stop and next start.

Parameters:
- CLKS_PER_BIT, 10417: clk cycles per serial bit; legal range >= 2.
- DATA_BITS, 32: data bits per frame; fixed at 32 for link compatibility.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  32  word to send; sampled on the acceptance edge.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding buffer empty; equals !buf_full, registered-state only, no combinational path from tx_valid.
- parity_type  input  1  sampled with tx_data. 1: parity bit = XOR of data (even). 0: parity bit = XNOR of data (odd).
- tx  output  1  serial line; registered; idles high.
- busy  output  1  high while the FSM is not IDLE or the holding buffer is full.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - tx=1, busy=0, holding buffer cleared so tx_ready=1, FSM=IDLE, bit timer=0, bit index=0.
  - No acceptance occurs while rst is high.
  - A partial frame is abandoned; the line returns high immediately.
- Acceptance: on a rising edge with tx_valid && tx_ready.
  - buf_data <= tx_data; buf_parity <= parity_type ? ^tx_data : ~^tx_data; buf_full <= 1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If buf_full, go to START on the next edge: tx<=0, shift_reg<=buf_data, par_reg<=buf_parity, buf_full<=0, timer<=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with tx<=shift_reg[0] and bit index=0.
  - DATA: each bit held CLKS_PER_BIT cycles, LSB first. At the end of a bit, shift right and increment the index. After index 31 completes, go to PARITY with tx<=par_reg.
  - PARITY: held CLKS_PER_BIT cycles, then STOP with tx<=1.
  - STOP: held CLKS_PER_BIT cycles.
    - At the end, if buf_full: go directly to START on the same edge (tx<=0, load from buffer, buf_full<=0).
    - Otherwise go to IDLE.
- Timer: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Width $clog2(CLKS_PER_BIT).
- Latency: acceptance at edge N while IDLE with buffer empty; buf_full=1 after N; tx falls at edge N+1.
- Frame length: exactly 35*CLKS_PER_BIT cycles from the tx falling edge to the end of the stop bit.
- Buffer:
  - Drains into the shifter only at the IDLE->START or STOP->START transition.
  - tx_ready rises the cycle after the drain edge, so accept and drain never coincide.
  - During a frame one further word may be accepted. tx_ready then stays 0 until that word is loaded.
- Input stability: tx_data and parity_type changes after acceptance have no effect on the frame in flight or the buffered word.
- tx_valid held high with tx_ready=0: no acceptance, no state change.

Decomposition:
- Package uart_pkg:
  - DATA_BITS and default CLKS_PER_BIT constants.
  - Frame state enum (IDLE, START, DATA, PARITY, STOP).
  - Parity function parity_bit(data, parity_type), reused by the receiver side.
- Sub-module uart_bit_timer:
  - Parameter CLKS_PER_BIT.
  - Inputs: clk, rst, clear, enable.
  - Output: bit_done, a single-cycle pulse when the count reaches CLKS_PER_BIT-1, wrapping to 0.

Test Plan:
- Single word, CLKS_PER_BIT=4: tx_data=0x0000_0001, parity_type=1 -> tx low from edge N+1 for 4 cycles, then bit0=1, bits1..31=0, parity=1, stop=1; total 140 cycles; busy falls after stop.
- Odd parity: 0xFFFF_FFFF, parity_type=0 -> 32 ones, parity bit=1. Also 0xA5A5_A5A5, parity_type=1 -> parity bit=0.
- Back-to-back: offer 0x1234_5678 then 0x8765_4321 with tx_valid held high -> second word accepted while the first transmits. tx_ready=0 until the second word is loaded. The second start bit begins on the cycle after the first stop's last cycle (no idle cycle). Decoded words match in order.
- Backpressure: tx_valid high with buffer full -> no acceptance, tx_data changed to 0xDEAD_BEEF mid-frame, buffered word unchanged on the line.
- Reset mid-frame: assert rst during DATA bit 10 -> tx=1 immediately, busy=0, tx_ready=1. After release, a new word 0x0000_00FF transmits as a complete, correct 35-bit frame.
- Parity sampling: toggle parity_type after acceptance of 0x0000_0003 (accepted with parity_type=1) -> parity bit=0, computed from the sampled value.
